path_tracer: RTL

Reads the per-node predecessor vector written by the visited/predecessor store after a shortest-path run.
Walks it from a destination back to the source and pushes each node onto an internal LIFO.
Then streams the path source-first over a valid/ready interface.
Sits downstream of the solver and feeds path output/readout logic.

---
 rtl/path_tracer_pkg.sv | 33 +++
 rtl/path_stack.sv | 52 +++++
 rtl/path_tracer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/path_tracer_pkg.sv
// Shared constants for the shortest-path tracer: sentinel, default sizes,
// FSM state encoding and trace error codes.
`ifndef UNVISITED
`define UNVISITED '1
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif

package path_tracer_pkg;

    localparam int DEFAULT_MAX_NODES   = `DEFAULT_MAX_NODES;
    localparam int DEFAULT_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WALK = 3'd1,
        ST_EMIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } tracer_state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_BAD_INDEX   = 2'd1,
        ERR_UNREACHABLE = 2'd2,
        ERR_LOOP        = 2'd3
    } err_code_t;

endpackage

// File: rtl/path_stack.sv
// LIFO of node indices: push/pop/clear, combinational top of stack.
// Push when full and pop when empty are ignored; contents are not reset.
module path_stack #(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_WIDTH-1:0]  push_data,
    output logic [DATA_WIDTH-1:0]  top,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [AW-1:0]          wr_addr;
    logic [AW-1:0]          top_addr;

    assign count    = count_q;
    assign full     = (count_q == COUNT_WIDTH'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_addr  = AW'(count_q);
    assign top_addr = AW'(count_q - COUNT_WIDTH'(1));
    assign top      = mem[top_addr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full && !clear) begin
            mem[wr_addr] <= push_data;
        end
    end

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor vector dest->source onto a LIFO, then streams it source-first.
// Latency: L walk cycles then L emit cycles at full rate; path_node holds while path_ready is low.
module path_tracer
    import path_tracer_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] dest,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [INDEX_WIDTH-1:0] prev_vector [MAX_NODES],
    output logic                   busy,
    output logic                   path_valid,
    input  logic                   path_ready,
    output logic [INDEX_WIDTH-1:0] path_node,
    output logic                   path_last,
    output logic [INDEX_WIDTH:0]   path_length,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
);

    localparam int CW = INDEX_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] UNVISITED_IDX = `UNVISITED;

    tracer_state_t          state, next_state;
    logic [INDEX_WIDTH-1:0] src_q;
    logic [INDEX_WIDTH-1:0] cur_q;
    logic [CW-1:0]          walk_len_q;
    logic [CW-1:0]          path_length_q;
    err_code_t              error_code_q;

    logic                   stk_clear, stk_push, stk_pop;
    logic [INDEX_WIDTH-1:0] stk_top;
    logic [CW-1:0]          sp;
    logic                   stk_full, stk_empty;

    logic [INDEX_WIDTH-1:0] prev_of_cur;
    logic [CW-1:0]          sp_next;
    logic [CW-1:0]          node_count;
    logic                   handshake;
    logic                   err_load;
    err_code_t              err_val;
    logic                   len_load;

    path_stack #(
        .DEPTH      (MAX_NODES),
        .DATA_WIDTH (INDEX_WIDTH),
        .COUNT_WIDTH(CW)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(cur_q),
        .top      (stk_top),
        .count    (sp),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // Indices beyond the vector read as unreached rather than out of range.
    always_comb begin
        prev_of_cur = UNVISITED_IDX;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (cur_q == INDEX_WIDTH'(i)) begin
                prev_of_cur = prev_vector[i];
            end
        end
    end

    assign sp_next    = sp + CW'(1);
    assign node_count = {1'b0, number_of_nodes};

    assign busy       = (state != ST_IDLE);
    assign path_valid = (state == ST_EMIT) && !stk_empty;
    assign path_node  = path_valid ? stk_top : '0;
    assign path_last  = path_valid && (sp == CW'(1));
    assign handshake  = path_valid && path_ready;
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERR);
    assign path_length = path_length_q;
    assign error_code  = error_code_q;

    always_comb begin
        next_state = state;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        err_load   = 1'b0;
        err_val    = ERR_NONE;
        len_load   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    stk_clear = 1'b1;
                    if ({1'b0, source} >= node_count || {1'b0, dest} >= node_count) begin
                        err_load   = 1'b1;
                        err_val    = ERR_BAD_INDEX;
                        next_state = ST_ERR;
                    end else begin
                        next_state = ST_WALK;
                    end
                end
            end
            ST_WALK: begin
                stk_push = !stk_full;
                // Reaching the source wins over both error checks.
                if (cur_q == src_q) begin
                    next_state = ST_EMIT;
                end else if (prev_of_cur == UNVISITED_IDX) begin
                    err_load   = 1'b1;
                    err_val    = ERR_UNREACHABLE;
                    next_state = ST_ERR;
                end else if (sp_next == node_count || sp_next == CW'(MAX_NODES)) begin
                    err_load   = 1'b1;
                    err_val    = ERR_LOOP;
                    next_state = ST_ERR;
                end
            end
            ST_EMIT: begin
                stk_pop = handshake;
                if (handshake && sp == CW'(1)) begin
                    len_load   = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            src_q         <= '0;
            cur_q         <= '0;
            walk_len_q    <= '0;
            path_length_q <= '0;
            error_code_q  <= ERR_NONE;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && start) begin
                src_q        <= source;
                cur_q        <= dest;
                error_code_q <= ERR_NONE;
            end
            if (state == ST_WALK) begin
                cur_q      <= prev_of_cur;
                walk_len_q <= sp_next;
            end
            if (err_load) begin
                error_code_q <= err_val;
            end
            if (len_load) begin
                path_length_q <= walk_len_q;
            end
        end
    end

endmodule
